// File: rtl/alu_sched_pkg.sv
// Shared types for functional-unit issue controllers.
// Opcode encoding, issue/result bundles and default widths.
package alu_sched_pkg;

  localparam int XLEN  = 64;
  localparam int TAG_W = 6;
  localparam int OP_W  = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0]  in1;
    logic [XLEN-1:0]  in2;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] tag;
  } alu_issue_t;

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag;
  } alu_result_t;

endpackage

// File: rtl/alu_int_issue_ctrl_alu.sv
// Combinational RV64I-style integer ALU.
// Unknown opcodes produce zero.
module ALU_int
  import alu_sched_pkg::*;
#(
  parameter int BIT_WIDTH  = 64,
  parameter int GATE_DELAY = 50
) (
  input  logic [BIT_WIDTH-1:0] in1,
  input  logic [BIT_WIDTH-1:0] in2,
  input  logic [OP_W-1:0]      op,
  output logic [BIT_WIDTH-1:0] result
);

  localparam int SW = $clog2(BIT_WIDTH);

  if (GATE_DELAY < 0) begin : g_neg_delay
  end

  logic [SW-1:0] shamt;
  logic          lt_s;
  logic          lt_u;

  assign shamt = in2[SW-1:0];
  assign lt_s  = $signed(in1) < $signed(in2);
  assign lt_u  = in1 < in2;

  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      ALU_ADD:  result = in1 + in2;
      ALU_SUB:  result = in1 - in2;
      ALU_SLL:  result = in1 << shamt;
      ALU_SLT:  result = {{(BIT_WIDTH-1){1'b0}}, lt_s};
      ALU_SLTU: result = {{(BIT_WIDTH-1){1'b0}}, lt_u};
      ALU_XOR:  result = in1 ^ in2;
      ALU_SRL:  result = in1 >> shamt;
      ALU_SRA:  result = $signed(in1) >>> shamt;
      ALU_OR:   result = in1 | in2;
      ALU_AND:  result = in1 & in2;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_int_issue_ctrl_arb.sv
// Round-robin arbiter: first valid request at or after ptr wins.
// Purely combinational; the owner keeps and advances ptr.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  // Walk from farthest to nearest so the nearest valid ends up winning.
  always_comb begin
    int j;
    j = 0;
    grant = '0;
    grant_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        grant_idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_int_issue_ctrl.sv
// Shared integer ALU issue controller: RR grant, operand reg, ALU,
// result reg driving a tagged CDB port with backpressure and flush.
module alu_int_issue_ctrl
  import alu_sched_pkg::*;
#(
  parameter int BIT_WIDTH  = 64,
  parameter int GATE_DELAY = 50,
  parameter int NUM_REQ    = 4,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][BIT_WIDTH-1:0]   req_in1,
  input  logic [NUM_REQ-1:0][BIT_WIDTH-1:0]   req_in2,
  input  logic [NUM_REQ-1:0][OP_W-1:0]        req_op,
  input  logic [NUM_REQ-1:0][TAG_WIDTH-1:0]   req_tag,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic                                flush,
  output logic                                cdb_valid,
  input  logic                                cdb_ready,
  output logic [BIT_WIDTH-1:0]                cdb_result,
  output logic [TAG_WIDTH-1:0]                cdb_tag,
  output logic                                busy
);

  localparam int PW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   grant;
  logic [PW-1:0]        grant_idx;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        ptr_next;

  logic                 s1_valid;
  logic [BIT_WIDTH-1:0] s1_in1;
  logic [BIT_WIDTH-1:0] s1_in2;
  logic [OP_W-1:0]      s1_op;
  logic [TAG_WIDTH-1:0] s1_tag;

  logic                 s2_valid;
  logic [BIT_WIDTH-1:0] s2_result;
  logic [TAG_WIDTH-1:0] s2_tag;

  logic [BIT_WIDTH-1:0] alu_res;
  logic                 s1_en;
  logic                 s2_en;
  logic                 take;
  logic                 accept;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  ALU_int #(
    .BIT_WIDTH  (BIT_WIDTH),
    .GATE_DELAY (GATE_DELAY)
  ) u_alu (
    .in1    (s1_in1),
    .in2    (s1_in2),
    .op     (s1_op),
    .result (alu_res)
  );

  assign s2_en  = !s2_valid || cdb_ready;
  assign s1_en  = !s1_valid || s2_en;
  assign take   = s1_en && !flush && !reset;
  assign req_ready = take ? grant : '0;
  assign accept = |(req_valid & req_ready);

  assign ptr_next = (int'(grant_idx) == NUM_REQ - 1) ?
                    '0 : grant_idx + PW'(1);

  assign cdb_valid  = s2_valid;
  assign cdb_result = s2_result;
  assign cdb_tag    = s2_tag;
  assign busy       = s1_valid || s2_valid;

  // Flush beats any CDB handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_in1    <= '0;
      s1_in2    <= '0;
      s1_op     <= '0;
      s1_tag    <= '0;
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_tag    <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_en) begin
        s2_valid  <= s1_valid;
        s2_result <= alu_res;
        s2_tag    <= s1_tag;
      end
      if (s1_en) begin
        s1_valid <= accept;
        s1_in1   <= req_in1[grant_idx];
        s1_in2   <= req_in2[grant_idx];
        s1_op    <= req_op[grant_idx];
        s1_tag   <= req_tag[grant_idx];
      end
      if (accept) rr_ptr <= ptr_next;
    end
  end

endmodule

// File: tb/tb_alu_int_issue_ctrl.sv
// Scoreboard bench for alu_int_issue_ctrl: directed scenarios
// followed by randomized traffic against a behavioural model.
module tb_alu_int_issue_ctrl;
  import alu_sched_pkg::*;

  localparam int N = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N-1:0]           req_valid;
  logic [N-1:0][63:0]     req_in1;
  logic [N-1:0][63:0]     req_in2;
  logic [N-1:0][3:0]      req_op;
  logic [N-1:0][5:0]      req_tag;
  logic [N-1:0]           req_ready;
  logic                   flush;
  logic                   cdb_valid;
  logic                   cdb_ready;
  logic [63:0]            cdb_result;
  logic [5:0]             cdb_tag;
  logic                   busy;

  int checks = 0;
  int failures = 0;
  alu_result_t q[$];
  int  mptr = 0;
  bit  post_kill = 0;
  bit  stall_prev = 0;
  alu_result_t held;

  alu_int_issue_ctrl #(
    .BIT_WIDTH(64), .GATE_DELAY(50), .NUM_REQ(N), .TAG_WIDTH(6)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_in1(req_in1), .req_in2(req_in2),
    .req_op(req_op), .req_tag(req_tag), .req_ready(req_ready),
    .flush(flush), .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
    .cdb_result(cdb_result), .cdb_tag(cdb_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference ALU written from the instruction semantics.
  function automatic logic [63:0] ref_alu(logic [3:0] op,
                                          logic [63:0] a,
                                          logic [63:0] b);
    int sh;
    logic [63:0] ones;
    sh = int'(b[5:0]);
    ones = '1;
    case (op)
      4'd0: return a + b;
      4'd1: return a + ~b + 64'd1;
      4'd2: return a << sh;
      4'd3: begin
        if (a[63] != b[63]) return {63'd0, a[63]};
        return {63'd0, a < b};
      end
      4'd4: return {63'd0, a < b};
      4'd5: return a ^ b;
      4'd6: return a >> sh;
      4'd7: return (a >> sh) | (a[63] ? ~(ones >> sh) : 64'd0);
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 70));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Evaluates the settled cycle: grant, occupancy and scoreboard push.
  task automatic check_and_push();
    int idx;
    bit can;
    logic [3:0] exp_rdy;
    if (reset) begin
      chk("rdy_in_reset", 64'(req_ready), 64'd0);
      q.delete();
      mptr = 0;
      post_kill = 1;
      return;
    end
    if (post_kill) begin
      chk("kill_cdb_valid", 64'(cdb_valid), 64'd0);
      chk("kill_busy", 64'(busy), 64'd0);
      post_kill = 0;
    end
    chk("busy", 64'(busy), 64'(q.size() != 0));
    idx = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (mptr + k) % N;
      if (idx < 0 && req_valid[j]) idx = j;
    end
    can = (idx >= 0) && !flush && (q.size() < 2 || cdb_ready);
    exp_rdy = can ? (4'b0001 << idx) : 4'b0000;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (can) begin
      q.push_back('{result: ref_alu(req_op[idx], req_in1[idx],
                                     req_in2[idx]),
                    tag: req_tag[idx]});
      mptr = (idx + 1) % N;
    end
    if (flush) begin
      q.delete();
      post_kill = 1;
    end
  endtask

  task automatic tick();
    #2;
    check_and_push();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all(logic [3:0] op, logic [63:0] a,
                          logic [63:0] b, logic [5:0] tbase);
    for (int i = 0; i < N; i++) begin
      req_op[i]  = op;
      req_in1[i] = a;
      req_in2[i] = b;
      req_tag[i] = tbase + 6'(i);
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = ($urandom_range(0, 99) < 60);
      req_op[i]    = 4'($urandom_range(0, 11));
      req_in1[i]   = rnd_opnd();
      req_in2[i]   = rnd_opnd();
      req_tag[i]   = 6'($urandom);
    end
  endtask

  // Monitor: pops on each delivered result and checks hold during stalls.
  always @(negedge clk) begin
    alu_result_t e;
    if (!reset) begin
      if (stall_prev) begin
        chk("hold_valid", 64'(cdb_valid), 64'd1);
        chk("hold_result", cdb_result, held.result);
        chk("hold_tag", 64'(cdb_tag), 64'(held.tag));
      end
      stall_prev = 0;
      if (!flush && cdb_valid === 1'b1) begin
        if (cdb_ready) begin
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL spurious_cdb: got tag %h expected none",
                     cdb_tag);
          end else begin
            e = q.pop_front();
            if (cdb_result !== e.result || cdb_tag !== e.tag) begin
              failures++;
              $display("FAIL cdb_data: got %h/%h expected %h/%h",
                       cdb_result, cdb_tag, e.result, e.tag);
            end
          end
        end else begin
          stall_prev = 1;
          held.result = cdb_result;
          held.tag = cdb_tag;
        end
      end
    end else begin
      stall_prev = 0;
    end
  end

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
  } corner_t;

  corner_t corners[5];

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    cdb_ready = 1'b1;
    req_valid = '0;
    load_all(4'd0, 64'd0, 64'd0, 6'd0);
    @(posedge clk);
    #1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_cdb_result", cdb_result, 64'd0);
    chk("rst_cdb_tag", 64'(cdb_tag), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // Single ADD latency
    req_valid = 4'b0001;
    req_op[0] = 4'(ALU_ADD);
    req_in1[0] = 64'd5;
    req_in2[0] = 64'd7;
    req_tag[0] = 6'd3;
    tick();
    chk("lat_c1_valid", 64'(cdb_valid), 64'd0);
    req_valid = '0;
    tick();
    chk("lat_c2_valid", 64'(cdb_valid), 64'd1);
    chk("lat_c2_result", cdb_result, 64'd12);
    chk("lat_c2_tag", 64'(cdb_tag), 64'd3);
    tick();
    chk("lat_c3_valid", 64'(cdb_valid), 64'd0);

    // Continuous stream, round-robin order
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      load_all(4'(ALU_XOR), 64'(c), 64'hF0, 6'(8 + 4 * (c % 4)));
      tick();
    end

    // Backpressure for three cycles mid-stream
    for (int c = 0; c < 9; c++) begin
      cdb_ready = !(c >= 3 && c <= 5);
      load_all(4'(ALU_ADD), 64'(100 + c), 64'(c), 6'(c * 4));
      tick();
    end
    cdb_ready = 1'b1;

    // Flush with two ops in flight
    for (int c = 0; c < 2; c++) begin
      load_all(4'(ALU_OR), 64'(c), 64'h100, 6'(40 + 4 * c));
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_cdb_valid", 64'(cdb_valid), 64'd0);
    for (int c = 0; c < 4; c++) tick();

    // Arithmetic corners
    corners[0] = '{4'(ALU_SUB), 64'd3, 64'd5};
    corners[1] = '{4'(ALU_SLT), '1, 64'd1};
    corners[2] = '{4'(ALU_SLTU), '1, 64'd1};
    corners[3] = '{4'(ALU_SLT), 64'h8000_0000_0000_0000, 64'd1};
    corners[4] = '{4'(ALU_SRA), 64'h8000_0000_0000_0000, 64'd63};
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      load_all(corners[c].op, corners[c].a, corners[c].b, 6'(20 + c));
      tick();
    end
    load_all(4'd13, 64'd9, 64'd9, 6'd33);
    tick();

    // Reset with both stages full
    cdb_ready = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cdb_ready = 1'b1;
    chk("rst2_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst2_busy", 64'(busy), 64'd0);
    load_all(4'(ALU_AND), '1, 64'h55, 6'd50);
    tick();
    for (int c = 0; c < 3; c++) tick();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      load_random();
      cdb_ready = ($urandom_range(0, 99) < 70);
      flush = ($urandom_range(0, 99) < 4);
      reset = ($urandom_range(0, 199) < 1);
      tick();
    end

    // Drain
    reset = 1'b0;
    flush = 1'b0;
    cdb_ready = 1'b1;
    req_valid = '0;
    for (int c = 0; c < 10 && q.size() > 0; c++) tick();
    tick();
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
